// File: rtl/ifu_fetch_ctrl_pkg.sv
// Shared types for the instruction fetch controller.
// Holds the FSM state encoding and reset constants.
package ifu_fetch_ctrl_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC = 32'h8000_0000;

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    HOLD,
    WAIT_PC
  } fetch_state_e;

endpackage

// File: rtl/ifu_fetch_ctrl_if.sv
// Fetch controller bus bundle: SRAM port, IDU handoff
// and WBU next-PC handshake.
interface ifu_fetch_ctrl_if;
  import ifu_fetch_ctrl_pkg::*;

  logic [XLEN-1:0] mem_pc;
  logic            mem_ready;
  logic            mem_valid;
  logic [XLEN-1:0] mem_inst;

  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] inst_pc;

  logic            npc_valid;
  logic            npc_ready;
  logic [XLEN-1:0] npc;

  modport master (
    output mem_pc,
    output mem_ready,
    input  mem_valid,
    input  mem_inst,
    output inst_valid,
    input  inst_ready,
    output inst,
    output inst_pc,
    input  npc_valid,
    output npc_ready,
    input  npc
  );

  modport slave (
    input  mem_pc,
    input  mem_ready,
    output mem_valid,
    output mem_inst,
    input  inst_valid,
    output inst_ready,
    input  inst,
    input  inst_pc,
    output npc_valid,
    input  npc_ready,
    output npc
  );

endinterface

// File: rtl/ifu_fetch_ctrl.sv
// Instruction fetch controller for a non-pipelined core:
// one SRAM fetch per instruction, then wait for the next PC.
module ifu_fetch_ctrl #(
  parameter int XLEN = ifu_fetch_ctrl_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC =
    ifu_fetch_ctrl_pkg::RESET_PC
) (
  input  logic             clk,
  input  logic             rst,
  ifu_fetch_ctrl_if.master bus,
  output logic             misalign,
  output logic [31:0]      fetch_count
);
  import ifu_fetch_ctrl_pkg::*;

  fetch_state_e state_q;
  fetch_state_e state_d;

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] inst_q;
  logic [XLEN-1:0] inst_pc_q;

  logic mem_ready_c;
  logic inst_valid_c;
  logic npc_ready_c;
  logic capture;
  logic hand_off;
  logic npc_take;

  always_comb begin
    state_d      = state_q;
    mem_ready_c  = 1'b0;
    inst_valid_c = 1'b0;
    npc_ready_c  = 1'b0;
    unique case (state_q)
      REQ: begin
        mem_ready_c = 1'b1;
        state_d     = WAIT;
      end
      WAIT: begin
        // ack rides on the data beat
        mem_ready_c = bus.mem_valid;
        if (bus.mem_valid) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        inst_valid_c = 1'b1;
        npc_ready_c  = bus.inst_ready;
        if (bus.inst_ready) begin
          state_d = bus.npc_valid ? REQ : WAIT_PC;
        end
      end
      WAIT_PC: begin
        npc_ready_c = 1'b1;
        if (bus.npc_valid) begin
          state_d = REQ;
        end
      end
      default: state_d = REQ;
    endcase
  end

  assign capture  = (state_q == WAIT) & bus.mem_valid;
  assign hand_off = (state_q == HOLD) & bus.inst_ready;
  assign npc_take = npc_ready_c & bus.npc_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= REQ;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q        <= RESET_PC;
      inst_q      <= '0;
      inst_pc_q   <= '0;
      misalign    <= 1'b0;
      fetch_count <= '0;
    end else begin
      if (capture) begin
        inst_q    <= bus.mem_inst;
        inst_pc_q <= pc_q;
      end
      if (hand_off) begin
        fetch_count <= fetch_count + 32'd1;
      end
      if (npc_take) begin
        pc_q <= bus.npc;
        if (bus.npc[1:0] != 2'b00) begin
          misalign <= 1'b1;
        end
      end
    end
  end

  // Nothing is offered on any handshake while rst is held.
  assign bus.mem_ready  = mem_ready_c & rst;
  assign bus.inst_valid = inst_valid_c & rst;
  assign bus.npc_ready  = npc_ready_c & rst;

  assign bus.mem_pc  = pc_q;
  assign bus.inst    = inst_q;
  assign bus.inst_pc = inst_pc_q;

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Bench for ifu_fetch_ctrl: SRAM responder model plus a
// fetch-sequence reference (pc, count, sticky misalign).
module tb_ifu_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk;
  logic        rst;
  logic        misalign;
  logic [31:0] fetch_count;

  ifu_fetch_ctrl_if bus ();

  ifu_fetch_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .misalign    (misalign),
    .fetch_count (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;

  logic [31:0] m_pc;
  int unsigned m_count;
  logic        m_mis;

  int sram_delay;
  int stale_req;

  function automatic logic [31:0] word(input logic [31:0] a);
    if (a == RST_PC) return 32'h0000_0413;
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // SRAM responder, decisions based on pre-edge snapshots
  logic        s_mr;
  logic        s_mv;
  logic [31:0] s_pc;
  int          stale_s;
  int          stale_seen;
  bit          busy;
  int          cnt;
  logic [31:0] addr;

  always @(negedge clk) begin
    s_mr    = bus.mem_ready;
    s_mv    = bus.mem_valid;
    s_pc    = bus.mem_pc;
    stale_s = stale_req;
  end

  always @(posedge clk) begin
    bit want;
    #1;
    want       = (stale_s != stale_seen);
    stale_seen = stale_s;
    if (!rst) begin
      busy          = 1'b0;
      bus.mem_valid = 1'b0;
      bus.mem_inst  = '0;
    end else if (!busy && bus.mem_valid) begin
      bus.mem_valid = 1'b0;
    end else if (busy && s_mv && s_mr) begin
      bus.mem_valid = 1'b0;
      busy          = 1'b0;
    end else if (s_mr && !busy) begin
      busy = 1'b1;
      addr = s_pc;
      cnt  = sram_delay;
      if (cnt == 0) begin
        bus.mem_valid = 1'b1;
        bus.mem_inst  = word(addr);
      end
    end else if (busy && !bus.mem_valid) begin
      cnt = cnt - 1;
      if (cnt <= 0) begin
        bus.mem_valid = 1'b1;
        bus.mem_inst  = word(addr);
      end
    end else if (want && !busy) begin
      bus.mem_valid = 1'b1;
      bus.mem_inst  = $urandom;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic abort_run(input string what);
    n_bad++;
    $display("FAIL %s: bound expired", what);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  endtask

  // One full instruction: REQ, WAIT, HOLD, hand-off, next PC.
  task automatic run_fetch(input int dly, input int hold,
                           input bit same, input int gap,
                           input logic [31:0] nxt,
                           input bit stale);
    logic [31:0] pc;
    logic [31:0] w;
    int waits;
    pc = m_pc;
    w  = word(pc);
    sram_delay = dly;
    n_cmp++;
    if (bus.mem_ready !== 1'b1 || bus.mem_pc !== pc) begin
      n_bad++;
      $display("FAIL req: ready=%b pc=%h want 1 %h",
               bus.mem_ready, bus.mem_pc, pc);
    end
    step();
    waits = 0;
    while (bus.mem_valid !== 1'b1 && waits < 20) begin
      n_cmp++;
      if (bus.mem_ready !== 1'b0 || bus.inst_valid !== 1'b0
          || bus.mem_pc !== pc) begin
        n_bad++;
        $display("FAIL wait: ready=%b ivld=%b pc=%h want 0 0 %h",
                 bus.mem_ready, bus.inst_valid, bus.mem_pc, pc);
      end
      waits++;
      step();
    end
    if (bus.mem_valid !== 1'b1) abort_run("sram_wait");
    n_cmp++;
    if (waits != dly) begin
      n_bad++;
      $display("FAIL latency: waits=%0d want %0d", waits, dly);
    end
    n_cmp++;
    if (bus.mem_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL ack: ready=%b want 1", bus.mem_ready);
    end
    step();
    n_cmp++;
    if (bus.inst_valid !== 1'b1 || bus.inst !== w
        || bus.inst_pc !== pc) begin
      n_bad++;
      $display("FAIL hold_data: v=%b inst=%h pc=%h want 1 %h %h",
               bus.inst_valid, bus.inst, bus.inst_pc, w, pc);
    end
    n_cmp++;
    if (fetch_count !== m_count || bus.mem_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL hold_state: cnt=%0d rdy=%b want %0d 0",
               fetch_count, bus.mem_ready, m_count);
    end
    for (int i = 0; i < hold; i++) begin
      bus.inst_ready = 1'b0;
      bus.npc_valid  = 1'($urandom_range(0, 1));
      bus.npc        = $urandom;
      if (stale) stale_req++;
      #1;
      n_cmp++;
      if (bus.npc_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL hold_npc_ready: %b want 0", bus.npc_ready);
      end
      step();
      n_cmp++;
      if (bus.inst_valid !== 1'b1 || bus.inst !== w
          || bus.inst_pc !== pc || fetch_count !== m_count
          || bus.mem_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL hold_stable: v=%b inst=%h cnt=%0d want 1 %h %0d",
                 bus.inst_valid, bus.inst, fetch_count, w, m_count);
      end
    end
    bus.inst_ready = 1'b1;
    bus.npc_valid  = same;
    bus.npc        = nxt;
    #1;
    n_cmp++;
    if (bus.npc_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL handoff_npc_ready: %b want 1", bus.npc_ready);
    end
    step();
    bus.inst_ready = 1'b0;
    bus.npc_valid  = 1'b0;
    m_count++;
    if (!same) begin
      for (int i = 0; i <= gap; i++) begin
        n_cmp++;
        if (bus.inst_valid !== 1'b0 || bus.npc_ready !== 1'b1
            || bus.mem_ready !== 1'b0 || fetch_count !== m_count) begin
          n_bad++;
          $display("FAIL wait_pc: v=%b nr=%b mr=%b cnt=%0d want 0 1 0 %0d",
                   bus.inst_valid, bus.npc_ready, bus.mem_ready,
                   fetch_count, m_count);
        end
        if (i == gap) begin
          bus.npc_valid = 1'b1;
          bus.npc       = nxt;
        end
        step();
      end
      bus.npc_valid = 1'b0;
    end
    m_pc = nxt;
    if (nxt[1:0] != 2'b00) m_mis = 1'b1;
    #1;
    n_cmp++;
    if (bus.mem_ready !== 1'b1 || bus.mem_pc !== m_pc) begin
      n_bad++;
      $display("FAIL next_req: rdy=%b pc=%h want 1 %h",
               bus.mem_ready, bus.mem_pc, m_pc);
    end
    n_cmp++;
    if (fetch_count !== m_count || misalign !== m_mis) begin
      n_bad++;
      $display("FAIL counters: cnt=%0d mis=%b want %0d %b",
               fetch_count, misalign, m_count, m_mis);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if (bus.mem_ready !== 1'b0 || bus.inst_valid !== 1'b0
        || bus.npc_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_hs: mr=%b iv=%b nr=%b want 0 0 0",
               bus.mem_ready, bus.inst_valid, bus.npc_ready);
    end
    n_cmp++;
    if (bus.mem_pc !== RST_PC || bus.inst !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_regs: pc=%h inst=%h want %h 0",
               bus.mem_pc, bus.inst, RST_PC);
    end
    n_cmp++;
    if (fetch_count !== 32'd0 || misalign !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_cnt: cnt=%0d mis=%b want 0 0",
               fetch_count, misalign);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.mem_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_release: mr=%b want 1", bus.mem_ready);
    end
  endtask

  task automatic test_first_fetch();
    run_fetch(0, 0, 1'b0, 1, 32'h8000_0004, 1'b0);
  endtask

  task automatic test_hold();
    run_fetch(0, 5, 1'b1, 0, 32'h8000_0008, 1'b1);
  endtask

  task automatic test_back_to_back();
    run_fetch(0, 0, 1'b1, 0, 32'h8000_0004, 1'b0);
  endtask

  task automatic test_mem_delay();
    run_fetch(3, 1, 1'b1, 0, 32'h8000_0100, 1'b0);
  endtask

  task automatic test_misalign();
    run_fetch(0, 0, 1'b1, 0, 32'h8000_0006, 1'b0);
    run_fetch(1, 2, 1'b0, 0, 32'h8000_0010, 1'b1);
    run_fetch(0, 0, 1'b1, 0, 32'h8000_0014, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] nxt;
    for (int k = 0; k < 40; k++) begin
      nxt = {8'h80, 22'($urandom), 2'b00};
      if ($urandom_range(0, 7) == 0) nxt[1:0] = 2'($urandom_range(1, 3));
      run_fetch(int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)),
                int'($urandom_range(0, 2)),
                nxt,
                1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_mid();
    sram_delay = 3;
    step();
    step();
    #1;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (bus.mem_ready !== 1'b0 || bus.inst_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset_hs: mr=%b iv=%b want 0 0",
               bus.mem_ready, bus.inst_valid);
    end
    n_cmp++;
    if (bus.mem_pc !== RST_PC || fetch_count !== 32'd0
        || misalign !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset_regs: pc=%h cnt=%0d mis=%b want %h 0 0",
               bus.mem_pc, fetch_count, misalign, RST_PC);
    end
    m_pc    = RST_PC;
    m_count = 0;
    m_mis   = 1'b0;
    step();
    step();
    rst = 1'b1;
    #1;
    run_fetch(0, 0, 1'b1, 0, 32'h8000_0004, 1'b0);
  endtask

  initial begin
    rst            = 1'b0;
    bus.inst_ready = 1'b0;
    bus.npc_valid  = 1'b0;
    bus.npc        = '0;
    sram_delay     = 0;
    stale_req      = 0;
    stale_seen     = 0;
    busy           = 1'b0;
    n_cmp          = 0;
    n_bad          = 0;
    m_pc           = RST_PC;
    m_count        = 0;
    m_mis          = 1'b0;
    test_reset();
    test_first_fetch();
    test_hold();
    test_back_to_back();
    test_mem_delay();
    test_misalign();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
